// File: rtl/cpu24_pkg.sv
// Shared CPU datapath widths and the register-bank FSM encoding.
// Read mux and the other 24-bit CPU blocks take their widths from here.
package cpu24_pkg;

   localparam int DATA_W   = 24;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 1 << ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } bank_state_t;

endpackage

// File: rtl/demux8_regbank_24bit_dekoder3ne8.sv
// 3-to-8 one-hot decoder with enable; purely combinational, zero latency.
// No handshake: output is all zeros whenever the enable is low.
module dekoder3ne8 (
   input  logic       en,
   input  logic [2:0] sel,
   output logic [7:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < 8; i++) begin
         if (en && (sel == 3'(i))) begin
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux8_regbank_24bit.sv
// Write side of the 24-bit register bank: decoded write into 8 registers, sequenced 8-cycle clear, written flags.
// Latency: write visible one edge after acceptance. WriteReady drops for the whole clear sequence; requester holds.
// ZERO_REG_EN: when defined, register 0 reads as zero and writes to it are accepted but discarded.
module demux8_regbank_24bit #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 3
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              WriteValid,
   output logic              WriteReady,
   input  logic [ADDR_W-1:0] WriteAddr,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              Clear,
   output logic              Busy,
   output logic [7:0]        Valid,
   output logic [DATA_W-1:0] Dalja0,
   output logic [DATA_W-1:0] Dalja1,
   output logic [DATA_W-1:0] Dalja2,
   output logic [DATA_W-1:0] Dalja3,
   output logic [DATA_W-1:0] Dalja4,
   output logic [DATA_W-1:0] Dalja5,
   output logic [DATA_W-1:0] Dalja6,
   output logic [DATA_W-1:0] Dalja7
);

   import cpu24_pkg::*;

`ifdef ZERO_REG_EN
   localparam logic [NUM_REGS-1:0] LIVE_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};
`else
   localparam logic [NUM_REGS-1:0] LIVE_MASK = '1;
`endif

   bank_state_t         state;
   logic [ADDR_W-1:0]   clr_cnt;
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] valid_q;

   logic                wr_acc;
   logic                clr_act;
   logic [NUM_REGS-1:0] wr_hot;
   logic [NUM_REGS-1:0] clr_hot;

   assign WriteReady = (state == IDLE);
   assign Busy       = (state == CLEAR);
   assign wr_acc     = WriteValid & WriteReady;
   assign clr_act    = (state == CLEAR);

   dekoder3ne8 u_wr_dec (
      .en     (wr_acc),
      .sel    (WriteAddr),
      .onehot (wr_hot)
   );

   dekoder3ne8 u_clr_dec (
      .en     (clr_act),
      .sel    (clr_cnt),
      .onehot (clr_hot)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         clr_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Clear) begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
               end
            end
            CLEAR: begin
               // Clear requests seen here are dropped; the sweep always runs to completion.
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == ADDR_W'(NUM_REGS - 1)) begin
                  state <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               clr_cnt <= '0;
            end
         endcase
      end
   end

   // The sweep and a write can never target the same cycle: writes only land in IDLE.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (!LIVE_MASK[i] || clr_hot[i]) begin
               regs[i]    <= '0;
               valid_q[i] <= 1'b0;
            end else if (wr_hot[i]) begin
               regs[i]    <= WriteData;
               valid_q[i] <= 1'b1;
            end
         end
      end
   end

   assign Valid  = valid_q;
   assign Dalja0 = regs[0];
   assign Dalja1 = regs[1];
   assign Dalja2 = regs[2];
   assign Dalja3 = regs[3];
   assign Dalja4 = regs[4];
   assign Dalja5 = regs[5];
   assign Dalja6 = regs[6];
   assign Dalja7 = regs[7];

endmodule

// File: tb/tb_demux8_regbank_24bit.sv
// Randomised and directed bench for demux8_regbank_24bit against a cycle-level reference model.
module tb_demux8_regbank_24bit;

`ifdef ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   logic        Clock;
   logic        Reset;
   logic        WriteValid;
   logic        WriteReady;
   logic [2:0]  WriteAddr;
   logic [23:0] WriteData;
   logic        Clear;
   logic        Busy;
   logic [7:0]  Valid;
   logic [23:0] dalja [8];

   demux8_regbank_24bit dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .WriteValid (WriteValid),
      .WriteReady (WriteReady),
      .WriteAddr  (WriteAddr),
      .WriteData  (WriteData),
      .Clear      (Clear),
      .Busy       (Busy),
      .Valid      (Valid),
      .Dalja0     (dalja[0]),
      .Dalja1     (dalja[1]),
      .Dalja2     (dalja[2]),
      .Dalja3     (dalja[3]),
      .Dalja4     (dalja[4]),
      .Dalja5     (dalja[5]),
      .Dalja6     (dalja[6]),
      .Dalja7     (dalja[7])
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   int vectors = 0;
   int miscompares = 0;

   // Reference model: bank contents, written flags, and clear progress.
   logic [23:0] m_reg [8];
   bit          m_val [8];
   bit          m_busy;
   int          m_pos;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] m_valid_vec();
      logic [7:0] v = '0;
      for (int i = 0; i < 8; i++) v[i] = m_val[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_reg[i] = '0;
         m_val[i] = 1'b0;
      end
      m_busy = 1'b0;
      m_pos  = 0;
   endtask

   task automatic model_edge(input bit wv, input int a, input logic [23:0] d, input bit clr);
      if (!m_busy) begin
         if (wv && !(ZR && a == 0)) begin
            m_reg[a] = d;
            m_val[a] = 1'b1;
         end
         if (clr) begin
            m_busy = 1'b1;
            m_pos  = 0;
         end
      end else begin
         m_reg[m_pos] = '0;
         m_val[m_pos] = 1'b0;
         m_pos++;
         if (m_pos == 8) m_busy = 1'b0;
      end
   endtask

   task automatic compare_all(input string tag);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_dalja%0d", tag, i), 32'(dalja[i]), 32'(m_reg[i]));
      end
      chk({tag, "_valid"}, 32'(Valid), 32'(m_valid_vec()));
      chk({tag, "_busy"},  32'(Busy),  32'(m_busy));
      chk({tag, "_ready"}, 32'(WriteReady), 32'(!m_busy));
   endtask

   // Drive inputs, let one rising edge happen, then compare on the falling edge.
   task automatic step(input bit wv, input int a, input logic [23:0] d, input bit clr, input string tag);
      WriteValid = wv;
      WriteAddr  = 3'(a);
      WriteData  = d;
      Clear      = clr;
      @(posedge Clock);
      model_edge(wv, a, d, clr);
      @(negedge Clock);
      compare_all(tag);
   endtask

   task automatic burst(input string tag);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, i, 24'h100000 + 24'(i), 1'b0, tag);
         chk({tag, "_rdy_hold"}, 32'(WriteReady), 32'd1);
      end
   endtask

   initial begin
      int busy_cycles;
      logic [23:0] rd;

      model_reset();
      WriteValid = 1'b0;
      WriteAddr  = '0;
      WriteData  = '0;
      Clear      = 1'b0;
      Reset      = 1'b0;
      repeat (2) @(negedge Clock);
      compare_all("rst");
      Reset = 1'b1;
      @(negedge Clock);
      compare_all("post_rst");

      // Single write after reset.
      step(1'b1, 5, 24'hABCDEF, 1'b0, "w5");
      chk("w5_data", 32'(dalja[5]), 32'h00ABCDEF);
      chk("w5_valid", 32'(Valid), 32'h20);
      step(1'b0, 0, 24'h0, 1'b0, "idle");

      // Burst fill.
      burst("burst");
      chk("burst_valid", 32'(Valid), ZR ? 32'hFE : 32'hFF);
      chk("burst_d3", 32'(dalja[3]), 32'h100003);
      chk("burst_d0", 32'(dalja[0]), ZR ? 32'h0 : 32'h100000);

      // Full clear: Busy high for exactly eight samples, zeroing in order.
      step(1'b0, 0, 24'h0, 1'b1, "clr_req");
      busy_cycles = 1;
      for (int k = 0; k < 12 && Busy; k++) begin
         step(1'b0, 0, 24'h0, 1'b1, "clr_run");
         if (Busy) busy_cycles++;
      end
      chk("clr_busy_len", 32'(busy_cycles), 32'd8);
      chk("clr_valid", 32'(Valid), 32'h00);

      // Write held across a clear is accepted only once Busy drops.
      burst("refill");
      step(1'b0, 0, 24'h0, 1'b1, "stall_clr");
      for (int k = 0; k < 8; k++) step(1'b1, 2, 24'h000123, 1'b0, "stall");
      chk("stall_d2_pre", 32'(dalja[2]), 32'h0);
      step(1'b1, 2, 24'h000123, 1'b0, "stall_acc");
      chk("stall_d2_post", 32'(dalja[2]), 32'h000123);

      // Clear and write on the same IDLE edge.
      step(1'b1, 4, 24'hFFFFFF, 1'b1, "sim");
      for (int k = 1; k <= 4; k++) begin
         step(1'b0, 0, 24'h0, 1'b0, "sim_run");
         chk($sformatf("sim_d4_e%0d", k), 32'(dalja[4]), 32'hFFFFFF);
      end
      step(1'b0, 0, 24'h0, 1'b0, "sim_run");
      chk("sim_d4_zero", 32'(dalja[4]), 32'h0);
      repeat (3) step(1'b0, 0, 24'h0, 1'b0, "sim_tail");

      // Reset three cycles into a clear.
      burst("prerst");
      step(1'b0, 0, 24'h0, 1'b1, "mrst_clr");
      repeat (3) step(1'b0, 0, 24'h0, 1'b0, "mrst_run");
      #1 Reset = 1'b0;
      model_reset();
      #1;
      chk("mrst_busy", 32'(Busy), 32'd0);
      chk("mrst_valid", 32'(Valid), 32'h00);
      compare_all("mrst");
      #2 Reset = 1'b1;
      @(negedge Clock);
      step(1'b1, 6, 24'h5A5A5A, 1'b0, "mrst_w6");
      chk("mrst_w6_data", 32'(dalja[6]), 32'h5A5A5A);

      // Randomised traffic.
      for (int n = 0; n < 400; n++) begin
         rd = 24'($urandom);
         step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), rd,
              ($urandom_range(0, 19) == 0), "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/demux8_regbank_24bit.md
# demux8_regbank_24bit

Write side of the 24-bit CPU register path: accepts one 24-bit write per cycle over a valid/ready handshake and routes it through a 3-to-8 decode into one of eight 24-bit registers. All eight registers are driven out in parallel to the 8-to-1 read multiplexer. The block also provides a sequenced bank clear and a per-register written flag.

## Interface
Parameters:
- DATA_W, 24, register/data width
- ADDR_W, 3, write address width; number of registers = 2**ADDR_W = 8

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- WriteValid  input  1  write request
- WriteReady  output  1  block can accept a write this cycle
- WriteAddr  input  3  target register index
- WriteData  input  24  write data
- Clear  input  1  single-cycle request to zero the whole bank
- Busy  output  1  clear sequence in progress
- Valid  output  8  bit i set = register i written since last clear/reset
- Dalja0..Dalja7  output  24 each  register contents, to the read mux

## Operation
- FSM states: IDLE, CLEAR. Reset (Reset=0) forces IDLE asynchronously.
- Reset values: Dalja0..7 = 24'h000000, Valid = 8'h00, Busy = 0, clear counter = 0. WriteReady = 1 as soon as Reset deasserts.
- WriteReady = (state == IDLE), combinational from state. Busy = (state == CLEAR).
- Write accepted on a rising edge with WriteValid & WriteReady. Decode WriteAddr one-hot, update only that register with WriteData, and set Valid[WriteAddr]. All other registers hold.
- WriteValid without WriteReady: nothing is written. The requester must hold Addr/Data until accepted.
- IDLE with Clear=1: go to CLEAR with counter = 0.
- CLEAR: on each cycle, zero register[counter], clear Valid[counter], then increment counter. When counter == 7, wrap to 0 and return to IDLE. The clear lasts exactly 8 cycles.
- Clear asserted while in CLEAR is ignored and does not restart the sequence.
- Clear and an accepted write in the same IDLE cycle: the write lands, then the clear starts next cycle and eventually wipes it.
- Reset during CLEAR: all registers and Valid go to zero immediately. State returns to IDLE and the counter to 0.
- WriteAddr is always in range (3 bits for 8 registers). There is no out-of-range case.

## Timing
- Write latency: a value accepted at edge N is visible on DaljaX and Valid after edge N.
- Back-to-back writes are accepted every cycle in IDLE. Two consecutive writes to the same address: last one wins.
- Clear requested at edge N: Busy=1 and WriteReady=0 after edge N. Register k is zeroed at edge N+1+k. Busy=0 and WriteReady=1 after edge N+8.
- Outputs are registered. Only WriteReady/Busy are decoded combinationally from the state register, and there is no input-to-output combinational path.

## Configuration
- ZERO_REG_EN defined: register 0 is hardwired. Dalja0 is constantly 24'h000000 and Valid[0] is constantly 0. Writes to address 0 are still handshaken and accepted, then discarded.
- ZERO_REG_EN undefined: register 0 behaves like registers 1..7.

## Structure
- Shared package cpu24_pkg holds:
  - DATA_W = 24, ADDR_W = 3, NUM_REGS = 8
  - the bank FSM state encoding (IDLE, CLEAR)
- Read mux and other CPU blocks take these widths from cpu24_pkg.
- One sub-module: Dekoder3ne8, a combinational 3-to-8 one-hot decoder with enable. It is instantiated twice, for the write enable and the clear-counter enable.

## Test plan
- Reset then write: after Reset released, write 24'hABCDEF to addr 5 -> Dalja5 = 24'hABCDEF next cycle, Valid = 8'h20, all other Dalja = 0.
- Burst: write addr 0..7 with data 24'h100000+i on 8 consecutive cycles -> WriteReady stays 1, Valid = 8'hFF, Dalja3 = 24'h100003. With ZERO_REG_EN: Dalja0 = 0, Valid = 8'hFE.
- Clear: from a full bank, pulse Clear -> Busy = 1 for exactly 8 cycles, registers zero in order 0..7, WriteReady = 0 throughout, then Valid = 8'h00.
- Write stall: hold WriteValid with addr 2 / 24'h000123 during clear -> not accepted until Busy drops, then Dalja2 = 24'h000123 one cycle later.
- Simultaneous: Clear and write (addr 4, 24'hFFFFFF) on the same IDLE edge -> Dalja4 = 24'hFFFFFF for 4 cycles, zeroed at the 5th clear edge.
- Reset mid-clear: assert Reset 3 cycles into a clear -> all outputs zero immediately, Busy = 0. After release, a write to addr 6 works normally.
